ide_fifo_gen: RTL and testbench

//  Parametrised sector FIFO between the IDE/ATAPI task-file controller and the host-side IO

---
 rtl/ide_pkg.sv | 31 +++
 rtl/ide_fifo_ram.sv | 49 ++++
 rtl/ide_fifo_gen.sv | 164 ++++++++++++++++
 tb/tb_ide_fifo_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// Shared IDE constants: sector geometry, word width and strobe-mode encodings
// used by the task-file FIFOs.
package ide_pkg;

    localparam int IDE_SEC_LOG2   = 8;
    localparam int IDE_WORD_W     = 16;
    localparam int IDE_DEPTH_LOG2 = 12;

    localparam int STROBE_LEVEL   = 0;
    localparam int STROBE_FALLING = 1;

    typedef enum logic [1:0] {
        FULL_SECTOR  = 2'd0,
        FULL_PKT_IN  = 2'd1,
        FULL_PKT_OUT = 2'd2
    } full_mode_e;

    // Pointer-advance request for one strobe under the selected strobe mode.
    function automatic logic strobe_adv(input logic falling_mode,
                                        input logic hist,
                                        input logic cur);
        logic adv;
        if (falling_mode) begin
            adv = hist & ~cur;
        end else begin
            adv = cur;
        end
        return adv;
    endfunction

endpackage

// File: rtl/ide_fifo_ram.sv
// Simple dual-port synchronous RAM with a registered read port; clk_en gates both
// ports and clr zeroes the read register.
module ide_fifo_ram
    import ide_pkg::*;
#(
    parameter int DATA_W = IDE_WORD_W,
    parameter int ADDR_W = IDE_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              clk_en,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk) begin
        if (clk_en && we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next read-register value
    always_comb begin
        rd_data_d = rd_data_q;
        if (clr) begin
            rd_data_d = '0;
        end else begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read register
    always_ff @(posedge clk) begin
        if (clk_en) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ide_fifo_gen.sv
// Parametrised sector FIFO between the IDE task-file controller and the host IO
// controller, with sector/packet availability, fill level and sticky error flags.
module ide_fifo_gen
    import ide_pkg::*;
#(
    parameter int DATA_W     = IDE_WORD_W,
    parameter int DEPTH_LOG2 = IDE_DEPTH_LOG2,
    parameter int SEC_LOG2   = IDE_SEC_LOG2,
    parameter int EDGE_MODE  = STROBE_FALLING
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_W-1:0]     data_out,
    input  logic                  packet_in,
    input  logic                  packet_out,
    input  logic [DEPTH_LOG2:0]   packet_count,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  packet_in_last,
    output logic                  last_in,
    output logic                  last_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               PTR_W    = DEPTH_LOG2 + 1;
    localparam logic             FALL     = (EDGE_MODE == STROBE_FALLING);
    localparam logic [PTR_W-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PTR_W-1:0] inptr_q, inptr_d;
    logic [PTR_W-1:0] outptr_q, outptr_d;
    logic             wr_hist_q, wr_hist_d;
    logic             rd_hist_q, rd_hist_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             empty_q, empty_d;

    logic             clr_s;
    logic [PTR_W-1:0] level_s;
    logic             at_cap_s;
    logic             at_zero_s;
    logic             wr_adv_s;
    logic             rd_adv_s;
    logic             ram_we_s;
    logic             ptr_eq_s;
    logic             cnt_hit_s;
    full_mode_e       full_mode_s;
    logic             full_s;

    assign clr_s     = reset | flush;
    assign level_s   = inptr_q - outptr_q;
    assign at_cap_s  = (level_s == CAPACITY);
    assign at_zero_s = (level_s == {PTR_W{1'b0}});
    assign wr_adv_s  = strobe_adv(FALL, wr_hist_q, wr);
    assign rd_adv_s  = strobe_adv(FALL, rd_hist_q, rd);
    assign ptr_eq_s  = (inptr_q == outptr_q);
    assign cnt_hit_s = (inptr_q == packet_count);
    // A full FIFO's write address aliases the oldest unread word, so block the write.
    assign ram_we_s  = wr & ~clr_s & ~at_cap_s;

    ide_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .clk_en  (clk_en),
        .clr     (clr_s),
        .we      (ram_we_s),
        .wr_addr (inptr_q[DEPTH_LOG2-1:0]),
        .wr_data (data_in),
        .rd_addr (outptr_q[DEPTH_LOG2-1:0]),
        .rd_data (data_out)
    );

    // Next-state for pointers, strobe history and sticky flags
    always_comb begin
        inptr_d     = inptr_q;
        outptr_d    = outptr_q;
        wr_hist_d   = wr_hist_q;
        rd_hist_d   = rd_hist_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        empty_d     = empty_q;
        if (clr_s) begin
            inptr_d     = {PTR_W{1'b0}};
            outptr_d    = {PTR_W{1'b0}};
            wr_hist_d   = 1'b0;
            rd_hist_d   = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            empty_d     = 1'b1;
        end else begin
            wr_hist_d = wr;
            rd_hist_d = rd;
            empty_d   = ptr_eq_s;
            if (wr_adv_s) begin
                if (at_cap_s) begin
                    overflow_d = 1'b1;
                end else begin
                    inptr_d = inptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                end
            end else begin
                inptr_d = inptr_q;
            end
            if (rd_adv_s) begin
                if (at_zero_s) begin
                    underflow_d = 1'b1;
                end else begin
                    outptr_d = outptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                end
            end else begin
                outptr_d = outptr_q;
            end
        end
    end

    // State registers, all qualified by clk_en
    always_ff @(posedge clk) begin
        if (clk_en) begin
            inptr_q     <= inptr_d;
            outptr_q    <= outptr_d;
            wr_hist_q   <= wr_hist_d;
            rd_hist_q   <= rd_hist_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            empty_q     <= empty_d;
        end
    end

    // Availability rule selected by packet mode; packet_in wins over packet_out
    always_comb begin
        full_mode_s = FULL_SECTOR;
        full_s      = 1'b0;
        if (packet_in) begin
            full_mode_s = FULL_PKT_IN;
        end else if (packet_out) begin
            full_mode_s = FULL_PKT_OUT;
        end else begin
            full_mode_s = FULL_SECTOR;
        end
        case (full_mode_s)
            FULL_PKT_IN:  full_s = cnt_hit_s & ~ptr_eq_s;
            FULL_PKT_OUT: full_s = cnt_hit_s;
            FULL_SECTOR:  full_s = (inptr_q[PTR_W-1:SEC_LOG2] != outptr_q[PTR_W-1:SEC_LOG2]);
            default:      full_s = 1'b0;
        endcase
    end

    assign level          = level_s;
    assign full           = full_s;
    assign empty          = ptr_eq_s | empty_q;
    assign packet_in_last = packet_in & cnt_hit_s & ptr_eq_s & (inptr_q != {PTR_W{1'b0}});
    assign last_in        = &inptr_q[SEC_LOG2-1:0];
    assign last_out       = &outptr_q[SEC_LOG2-1:0];
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_ide_fifo_gen.sv
// Directed bench: a falling-edge 4096-word FIFO and a small level-strobe FIFO.
module tb_ide_fifo_gen;

    logic        clk = 1'b0;
    logic        reset, clk_en;
    logic        f1, w1, r1, pin1, pout1;
    logic [15:0] d1, dout1;
    logic [12:0] pcnt1, lvl1;
    logic        full1, emp1, pil1, lin1, lout1, ovf1, unf1;
    logic        f0, w0, r0, pz;
    logic [15:0] d0, dout0;
    logic [4:0]  pcnt0, lvl0;
    logic        full0, emp0, pil0, lin0, lout0, ovf0, unf0;

    int total = 0;
    int bad   = 0;
    logic [15:0] got;

    always #5 clk = ~clk;

    ide_fifo_gen #(.DATA_W(16), .DEPTH_LOG2(12), .SEC_LOG2(8), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(f1), .data_in(d1),
        .wr(w1), .rd(r1), .data_out(dout1), .packet_in(pin1), .packet_out(pout1),
        .packet_count(pcnt1), .level(lvl1), .full(full1), .empty(emp1),
        .packet_in_last(pil1), .last_in(lin1), .last_out(lout1),
        .overflow(ovf1), .underflow(unf1)
    );

    ide_fifo_gen #(.DATA_W(16), .DEPTH_LOG2(4), .SEC_LOG2(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(f0), .data_in(d0),
        .wr(w0), .rd(r0), .data_out(dout0), .packet_in(pz), .packet_out(pz),
        .packet_count(pcnt0), .level(lvl0), .full(full0), .empty(emp0),
        .packet_in_last(pil0), .last_in(lin0), .last_out(lout0),
        .overflow(ovf0), .underflow(unf0)
    );

    typedef struct {
        logic        flush, wr, rd;
        logic [15:0] din;
        logic [4:0]  lvl;
        logic        emp, ful, lin, unf, chk;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pw(input logic [15:0] d);
        w1 = 1'b1; d1 = d; step();
        w1 = 1'b0; step();
    endtask

    task automatic pr(output logic [15:0] q);
        r1 = 1'b1; step();
        q  = dout1;
        r1 = 1'b0; step();
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1;
        f1 = 1'b0; w1 = 1'b0; r1 = 1'b0; pin1 = 1'b0; pout1 = 1'b0;
        d1 = 16'h0000; pcnt1 = 13'd0;
        f0 = 1'b0; w0 = 1'b0; r0 = 1'b0; pz = 1'b0; d0 = 16'h0000; pcnt0 = 5'd0;

        //              flush wr    rd    din        lvl   emp   ful   lin   unf   chk   dout
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'hA0A0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'hA1A1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA0A0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'hA2A2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA0A0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'hA3A3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA0A0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'hA4A4, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA0A0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'hA5A5, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA1A1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'hA6A6, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA2A2};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA3A3};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA4A4};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA6A6};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};

        step(); step();
        reset = 1'b0;
        check("rst_level", 32'(lvl1), 32'd0);
        check("rst_empty", 32'(emp1), 32'd1);
        check("rst_full", 32'(full1), 32'd0);
        check("rst_flags", 32'({ovf1, unf1}), 32'd0);
        check("rst_dout", 32'(dout1), 32'd0);

        // Level-strobe FIFO vector table
        for (int i = 0; i < 13; i++) begin
            f0 = tbl[i].flush; w0 = tbl[i].wr; r0 = tbl[i].rd; d0 = tbl[i].din;
            step();
            check($sformatf("v%0d_level", i), 32'(lvl0), 32'(tbl[i].lvl));
            check($sformatf("v%0d_empty", i), 32'(emp0), 32'(tbl[i].emp));
            check($sformatf("v%0d_full", i), 32'(full0), 32'(tbl[i].ful));
            check($sformatf("v%0d_last_in", i), 32'(lin0), 32'(tbl[i].lin));
            check($sformatf("v%0d_underflow", i), 32'(unf0), 32'(tbl[i].unf));
            if (tbl[i].chk) begin
                check($sformatf("v%0d_dout", i), 32'(dout0), 32'(tbl[i].dout));
            end
        end
        f0 = 1'b0; w0 = 1'b0; r0 = 1'b0;

        // Level strobe: simultaneous read and write at level 10
        for (int i = 0; i < 10; i++) begin
            w0 = 1'b1; d0 = 16'(i); step();
        end
        check("lvl10_fill", 32'(lvl0), 32'd10);
        r0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("lvl10_rw%0d", i), 32'(lvl0), 32'd10);
        end
        w0 = 1'b0; r0 = 1'b0;

        // Sector of 256 words, falling-edge strobes
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                check("last_in_w255", 32'(lin1), 32'd1);
                check("full_before_256", 32'(full1), 32'd0);
            end
            pw(16'h5A00 ^ 16'(i));
        end
        check("sec_full", 32'(full1), 32'd1);
        check("sec_level", 32'(lvl1), 32'd256);
        for (int i = 0; i < 256; i++) begin
            pr(got);
            check($sformatf("sec_rd%0d", i), 32'(got), 32'(16'h5A00 ^ 16'(i)));
        end
        check("sec_full_clr", 32'(full1), 32'd0);
        check("sec_empty", 32'(emp1), 32'd1);
        check("sec_level0", 32'(lvl1), 32'd0);

        // ATAPI packet receive and transmit
        f1 = 1'b1; step(); f1 = 1'b0;
        pin1 = 1'b1; pcnt1 = 13'd6;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("pkt_full_at5", 32'(full1), 32'd0);
            pw(16'h0C00 + 16'(i));
        end
        check("pkt_full", 32'(full1), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("pkt_last_at5", 32'(pil1), 32'd0);
            pr(got);
        end
        check("pkt_in_last", 32'(pil1), 32'd1);
        check("pkt_full_drained", 32'(full1), 32'd0);
        pin1 = 1'b0; pout1 = 1'b1;
        #1;
        check("pkt_out_full", 32'(full1), 32'd1);
        pout1 = 1'b0;

        // clk_en low freezes everything
        f1 = 1'b1; step(); f1 = 1'b0;
        for (int i = 0; i < 5; i++) pw(16'h4000 + 16'(i));
        step();
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w1 = i[0]; r1 = ~i[0]; w0 = i[0]; r0 = i[0]; d1 = 16'hFFFF - 16'(i);
            step();
        end
        w1 = 1'b0; r1 = 1'b0; w0 = 1'b0; r0 = 1'b0;
        check("cke_level", 32'(lvl1), 32'd5);
        check("cke_dout", 32'(dout1), 32'h4000);
        clk_en = 1'b1; step();
        check("cke_level_after", 32'(lvl1), 32'd5);
        check("cke_dout_after", 32'(dout1), 32'h4000);

        // Reset, then flush, mid-burst at level 100
        for (int i = 5; i < 100; i++) pw(16'h4000 + 16'(i));
        check("burst_level", 32'(lvl1), 32'd100);
        reset = 1'b1; w1 = 1'b1; step(); reset = 1'b0; w1 = 1'b0;
        check("rst_mid_level", 32'(lvl1), 32'd0);
        check("rst_mid_empty", 32'(emp1), 32'd1);
        check("rst_mid_flags", 32'({ovf1, unf1}), 32'd0);
        check("rst_mid_dout", 32'(dout1), 32'd0);
        for (int i = 0; i < 100; i++) pw(16'h7000 + 16'(i));
        step();
        check("fl_pre_dout", 32'(dout1), 32'h7000);
        f1 = 1'b1; r1 = 1'b1; step(); f1 = 1'b0; r1 = 1'b0;
        check("fl_mid_level", 32'(lvl1), 32'd0);
        check("fl_mid_empty", 32'(emp1), 32'd1);
        check("fl_mid_dout", 32'(dout1), 32'd0);

        // Overflow at 4096 words, then underflow on empty
        for (int i = 0; i < 4096; i++) pw(16'(i + 1));
        check("ovf_fill_level", 32'(lvl1), 32'd4096);
        check("ovf_fill_flag", 32'(ovf1), 32'd0);
        pw(16'hDEAD);
        check("ovf_level", 32'(lvl1), 32'd4096);
        check("ovf_flag", 32'(ovf1), 32'd1);
        pr(got);
        check("ovf_word0", 32'(got), 32'd1);
        check("ovf_level_rd", 32'(lvl1), 32'd4095);
        f1 = 1'b1; step(); f1 = 1'b0;
        pr(got);
        check("unf_flag", 32'(unf1), 32'd1);
        check("unf_level", 32'(lvl1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
